// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM states and default width.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIXUP,
        DONE
    } state_t;

    localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder is always below the divisor, so the stored value never needs
    // its top bit; the WIDTH+1-bit subtract still catches the shifted-in overflow case.
    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {1'b0, dmag_i};
    assign qbit_o  = ~trial[WIDTH];
    assign rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Sequential signed/unsigned restoring divider, fixed WIDTH+2 cycle latency, one op in flight.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic             signed_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dmag_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dz_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH-1:0] rem_d;
    logic             qbit_d;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (shift_q[WIDTH-1]),
        .dmag_i (dmag_q),
        .rem_o  (rem_d),
        .qbit_o (qbit_d)
    );

    assign a_neg = signed_q & dividend_q[WIDTH-1];
    assign b_neg = signed_q & divisor_q[WIDTH-1];
    assign a_mag = a_neg ? -dividend_q : dividend_q;
    assign b_mag = b_neg ? -divisor_q : divisor_q;
    // After the last step the shift register holds the quotient magnitude.
    assign q_fix = q_neg_q ? -shift_q : shift_q;
    assign r_fix = r_neg_q ? -rem_q : rem_q;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            signed_q    <= 1'b0;
            shift_q     <= '0;
            rem_q       <= '0;
            dmag_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dividend_q <= dividend;
                        divisor_q  <= divisor;
                        signed_q   <= is_signed;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
                    shift_q <= a_mag;
                    dmag_q  <= b_mag;
                    rem_q   <= '0;
                    q_neg_q <= a_neg ^ b_neg;
                    r_neg_q <= a_neg;
                    dz_q    <= (divisor_q == '0);
                    cnt_q   <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    rem_q   <= rem_d;
                    shift_q <= {shift_q[WIDTH-2:0], qbit_d};
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (dz_q) begin
                        quotient_q  <= '1;
                        remainder_q <= dividend_q;
                        dbz_q       <= 1'b1;
                    end else begin
                        quotient_q  <= q_fix;
                        remainder_q <= r_fix;
                        dbz_q       <= 1'b0;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: latency, signed/unsigned results, backpressure, reset.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, wait for the accept edge, then count cycles to out_valid.
    task automatic start_and_wait(input string tag, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] b);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        in_valid  = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        tick();
        in_valid  = 1'b0;
        dividend  = 32'hDEADBEEF;
        divisor   = 32'h00000003;
        is_signed = ~sgn;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd34);
    endtask

    task automatic check_result(input string tag, input logic [31:0] eq,
                                input logic [31:0] er, input logic edz);
        chk({tag, "_quot"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        $display("op %s: q=%h r=%h dz=%0b", tag, quotient, remainder, div_by_zero);
    endtask

    // With out_ready high the handshake completes at the next edge.
    task automatic check_handshake(input string tag);
        tick();
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) tick();

        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quot", quotient, 32'd0);
        chk("reset_rem", remainder, 32'd0);
        chk("reset_dz", 32'(div_by_zero), 32'd0);
        resetn = 1'b1;
        tick();

        start_and_wait("u100_7", 1'b0, 32'd100, 32'd7);
        check_result("u100_7", 32'd14, 32'd2, 1'b0);
        check_handshake("u100_7");

        start_and_wait("sm100_7", 1'b1, 32'hFFFFFF9C, 32'd7);
        check_result("sm100_7", 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        check_handshake("sm100_7");

        start_and_wait("s100_m7", 1'b1, 32'd100, 32'hFFFFFFF9);
        check_result("s100_m7", 32'hFFFFFFF2, 32'd2, 1'b0);
        check_handshake("s100_m7");

        start_and_wait("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
        check_result("sm7_2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        check_handshake("sm7_2");

        start_and_wait("dz", 1'b1, 32'h12345678, 32'd0);
        check_result("dz", 32'hFFFFFFFF, 32'h12345678, 1'b1);
        check_handshake("dz");

        start_and_wait("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        check_result("s_ovf", 32'h80000000, 32'd0, 1'b0);
        check_handshake("s_ovf");

        start_and_wait("u_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF);
        check_result("u_ovf", 32'd0, 32'h80000000, 1'b0);
        check_handshake("u_ovf");

        // Backpressure: results must hold and new operands must be ignored.
        out_ready = 1'b0;
        start_and_wait("bp", 1'b0, 32'd1000, 32'd33);
        check_result("bp", 32'd30, 32'd10, 1'b0);
        in_valid  = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd77;
        divisor   = 32'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_quot", quotient, 32'd30);
            chk("bp_hold_rem", remainder, 32'd10);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_handshake("bp");
        repeat (3) tick();
        chk("bp_no_ghost_op", 32'(in_ready), 32'd1);

        // Reset mid-calculation, around CALC iteration 15.
        start_and_wait("pre_rst_dummy_skip", 1'b0, 32'd9, 32'd3);
        check_result("pre_rst", 32'd3, 32'd0, 1'b0);
        check_handshake("pre_rst");
        in_valid  = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'hCAFEF00D;
        divisor   = 32'd13;
        tick();
        in_valid = 1'b0;
        repeat (16) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", quotient, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
        repeat (40) tick();
        chk("rst_abandoned", 32'(out_valid), 32'd0);

        start_and_wait("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1);
        check_result("u_max_1", 32'hFFFFFFFF, 32'd0, 1'b0);
        check_handshake("u_max_1");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Sequential radix-2 restoring integer divider, signed or unsigned per operation.
- Inverse-direction counterpart to the team's Booth-recoded multiplier datapath; sits beside it in the ALU's multi-cycle unit.
- Accepts one operand pair over a valid/ready handshake and returns quotient and remainder over a second valid/ready handshake.
- Fixed latency, one operation in flight.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  synchronous reset, active-low
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
is_signed  input  1  1 = two's-complement operation, 0 = unsigned; sampled at accept
dividend  input  WIDTH  dividend, sampled at accept
divisor  input  WIDTH  divisor, sampled at accept
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  quotient, registered
remainder  output  WIDTH  remainder, registered
div_by_zero  output  1  flag for current result (divisor was 0), registered

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE; out_valid=0; quotient, remainder and div_by_zero=0; iteration counter=0. Reset at any point mid-operation abandons the operation with no output.
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are combinational from state only.
- Accept: in_valid & in_ready at an edge latches the operands and is_signed, then moves to PREP.
- PREP (1 cycle):
  - Compute magnitudes |dividend| and |divisor| (magnitude used only when is_signed and MSB=1).
  - Record q_neg = is_signed & (dividend MSB ^ divisor MSB); r_neg = is_signed & dividend MSB; dz = (divisor==0).
  - Clear the partial remainder (WIDTH+1 bits); load the dividend magnitude into the shift register; counter=0.
  - Go to CALC.
- CALC (exactly WIDTH cycles), each cycle:
  - trial = {partial_rem[WIDTH-1:0], shift MSB} - {1'b0, divisor_mag}.
  - If trial is non-negative: partial_rem=trial and the quotient bit is 1. Otherwise restore and the quotient bit is 0.
  - Shift the quotient bit into the LSB; counter+1.
  - Go to FIXUP after the counter reaches WIDTH-1.
- FIXUP (1 cycle), registers the outputs:
  - If dz: quotient = all ones; remainder = original dividend; div_by_zero=1.
  - Else: quotient = q_neg ? -q : q; remainder = r_neg ? -r : r; div_by_zero=0.
  - Go to DONE.
- DONE: hold all outputs stable until out_ready=1, then go to IDLE. The next accept is possible one cycle after the result handshake (no same-cycle turnaround).
- Latency: out_valid rises WIDTH+2 cycles after the accept edge, independent of operand values (div-by-zero included).
- Signed overflow (most-negative / -1, signed): the magnitude 2^(WIDTH-1) is handled unsigned, so the result is quotient = most-negative, remainder = 0. No special case and no flag.
- Arithmetic: all magnitudes are WIDTH-bit unsigned; the subtract is WIDTH+1 bits; results wrap modulo 2^WIDTH.
- Inputs are ignored outside IDLE; operand changes after accept have no effect.

Decomposition:
- Shared package div_pkg: state enum (IDLE, PREP, CALC, FIXUP, DONE) and the default WIDTH constant.
- Counter width is $clog2(WIDTH), local to the module.
- One combinational sub-module div_step: inputs partial remainder, incoming bit and divisor magnitude; outputs next partial remainder and quotient bit.
- The FSM, shift registers and sign fix-up stay in div_iter.

Test Plan:
- Unsigned 100 / 7, out_ready held 1 -> quotient=14, remainder=2, div_by_zero=0; out_valid rises exactly 34 cycles after accept; in_ready returns 1 the cycle after the result handshake.
- Signed -100 / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Signed 100 / -7 -> quotient=-14, remainder=2.
- Divide by zero, signed, dividend=0x12345678, divisor=0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, latency still 34.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. The same operands unsigned -> quotient=0, remainder=0x80000000.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is ignored; operation completes on out_ready=1.
- resetn low for 1 cycle at CALC iteration 15 -> next cycle in_ready=1, out_valid=0, outputs 0. A following unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
